// File: rtl/cacheline_adapter.sv
// Cache-line to burst adapter: turns one 256-bit line read/write from the
// arbiter into a 4 x 64-bit burst on the banked memory port. It acknowledges
// each request with a single registered dfp_resp pulse.
module cacheline_adapter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   dfp_addr,
  input  logic                          dfp_read,
  input  logic                          dfp_write,
  input  logic [BEAT_W*BURST_LEN-1:0]   dfp_wdata,
  output logic [BEAT_W*BURST_LEN-1:0]   dfp_rdata,
  output logic                          dfp_resp,
  output logic [31:0]                   bmem_addr,
  output logic                          bmem_read,
  output logic                          bmem_write,
  output logic [BEAT_W-1:0]             bmem_wdata,
  input  logic                          bmem_ready,
  input  logic [31:0]                   bmem_raddr,
  input  logic [BEAT_W-1:0]             bmem_rdata,
  input  logic                          bmem_rvalid
);
  localparam int LINE_W = BEAT_W * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [31:0] OFF_MASK = 32'((1 << OFF_W) - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP} state_t;

  state_t                            state;
  logic [CNT_W-1:0]                  cnt;
  logic [31:0]                       line_addr;
  logic [BURST_LEN-1:0][BEAT_W-1:0]  line_buf;
  logic                              last_beat;
  logic                              beat_hit;

  assign last_beat = (cnt == CNT_W'(BURST_LEN - 1));
  // Only beats tagged with our own line address belong to this burst.
  assign beat_hit  = bmem_rvalid && (bmem_raddr == line_addr);

  // Request sequencing; dfp_resp is set on the edge that enters RESP so it
  // lines up with the RESP cycle without any path from the dfp_* inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_addr <= '0;
      line_buf  <= '0;
      dfp_resp  <= 1'b0;
    end else begin
      dfp_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (dfp_write) begin
            line_addr <= dfp_addr & ~OFF_MASK;
            line_buf  <= dfp_wdata;
            cnt       <= '0;
            state     <= WR_DATA;
          end else if (dfp_read) begin
            line_addr <= dfp_addr & ~OFF_MASK;
            cnt       <= '0;
            state     <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (beat_hit) begin
            line_buf[cnt] <= bmem_rdata;
            cnt           <= cnt + 1'b1;
            if (last_beat) begin
              state    <= RESP;
              dfp_resp <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (bmem_ready) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state    <= RESP;
              dfp_resp <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs decode from registered state/cnt/buffer only.
  always_comb begin
    bmem_read  = (state == RD_REQ);
    bmem_write = (state == WR_DATA);
    bmem_addr  = (bmem_read || bmem_write) ? line_addr : '0;
    bmem_wdata = bmem_write ? line_buf[cnt] : '0;
    dfp_rdata  = line_buf;
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: read/write bursts, stalls, gaps,
// stray beats, read/write priority, mid-burst reset and back-to-back traffic.
module tb_cacheline_adapter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int rw_both = 0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dfp_resp) resp_cnt++;
    if (bmem_read && bmem_write) rw_both++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full read transaction with back-to-back beats; ends one cycle after resp.
  task automatic rd_line(input string tag, input logic [31:0] a, input logic [3:0][63:0] bt);
    int n;
    dfp_addr = a; dfp_read = 1'b1; bmem_ready = 1'b1;
    n = 0;
    tick;
    while (!bmem_read && n < 20) begin tick; n++; end
    chk({tag, "_cmd"}, bmem_read, 1'b1);
    chk({tag, "_addr"}, bmem_addr, a & 32'hFFFF_FFE0);
    tick;
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = a & 32'hFFFF_FFE0; bmem_rdata = bt[k];
      tick;
    end
    bmem_rvalid = 1'b0; dfp_read = 1'b0;
    chk({tag, "_resp"}, dfp_resp, 1'b1);
    chk({tag, "_rdata"}, dfp_rdata, bt);
    tick;
    chk({tag, "_resp_drop"}, dfp_resp, 1'b0);
  endtask

  // Full write transaction with bmem_ready high; ends one cycle after resp.
  task automatic wr_line(input string tag, input logic [31:0] a, input logic [3:0][63:0] bt);
    dfp_addr = a; dfp_write = 1'b1; dfp_wdata = bt; bmem_ready = 1'b1;
    tick;
    dfp_wdata = ~bt;
    chk({tag, "_wr"}, bmem_write, 1'b1);
    chk({tag, "_addr"}, bmem_addr, a & 32'hFFFF_FFE0);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_beat"}, bmem_wdata, bt[k]);
      chk({tag, "_no_rd"}, bmem_read, 1'b0);
      tick;
    end
    dfp_write = 1'b0; dfp_read = 1'b0;
    chk({tag, "_resp"}, dfp_resp, 1'b1);
    chk({tag, "_idle_wr"}, bmem_write, 1'b0);
    tick;
    chk({tag, "_resp_drop"}, dfp_resp, 1'b0);
  endtask

  logic [3:0][63:0] bt1, bt2, bt3, bt4, bt5, bt6;
  int base;

  initial begin
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    bt1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    bt2 = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
           64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    bt3 = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
           64'h0101_0101_0101_0101, 64'h0000_0000_0000_00F0};
    bt4 = {64'h5555_5555_0000_0004, 64'h5555_5555_0000_0003,
           64'h5555_5555_0000_0002, 64'h5555_5555_0000_0001};
    bt5 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
           64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    bt6 = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
           64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
    tick; tick;
    chk("rst_resp", dfp_resp, 1'b0);
    chk("rst_rdata", dfp_rdata, '0);
    chk("rst_bread", bmem_read, 1'b0);
    chk("rst_bwrite", bmem_write, 1'b0);
    chk("rst_baddr", bmem_addr, '0);
    chk("rst_bwdata", bmem_wdata, '0);
    // stale beat in IDLE must not disturb anything
    bmem_rvalid = 1'b1; bmem_rdata = 64'hFFFF; bmem_raddr = '0;
    rst = 1'b0;
    tick;
    bmem_rvalid = 1'b0;
    chk("idle_stale", dfp_rdata, '0);

    // 1: minimum-latency read of 0x1004
    dfp_addr = 32'h0000_1004; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick;
    chk("t1_bread", bmem_read, 1'b1);
    chk("t1_baddr", bmem_addr, 32'h0000_1000);
    tick;
    chk("t1_bread_off", bmem_read, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_no_early_resp", dfp_resp, 1'b0);
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_1000; bmem_rdata = bt1[k];
      tick;
    end
    bmem_rvalid = 1'b0; dfp_read = 1'b0;
    chk("t1_resp", dfp_resp, 1'b1);
    chk("t1_rdata", dfp_rdata, bt1);
    tick;
    chk("t1_resp_1cyc", dfp_resp, 1'b0);
    chk("t1_rdata_hold", dfp_rdata, bt1);

    // 2: write 0x2000 with 3-cycle stall on beat 1
    dfp_addr = 32'h0000_2000; dfp_write = 1'b1; dfp_wdata = bt2;
    tick;
    dfp_wdata = '0; dfp_addr = 32'h0000_F000;
    chk("t2_bwrite", bmem_write, 1'b1);
    chk("t2_baddr", bmem_addr, 32'h0000_2000);
    chk("t2_beatA", bmem_wdata, bt2[0]);
    tick;
    bmem_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) bmem_ready = 1'b1;
      chk("t2_beatB_held", bmem_wdata, bt2[1]);
      chk("t2_stall_noresp", dfp_resp, 1'b0);
      tick;
    end
    chk("t2_beatC", bmem_wdata, bt2[2]);
    tick;
    chk("t2_beatD", bmem_wdata, bt2[3]);
    chk("t2_noresp_D", dfp_resp, 1'b0);
    tick;
    dfp_write = 1'b0;
    chk("t2_resp", dfp_resp, 1'b1);
    chk("t2_rdata_wline", dfp_rdata, bt2);
    tick;
    chk("t2_resp_1cyc", dfp_resp, 1'b0);

    // 3: read with command stall, gapped beats and a stray beat
    base = resp_cnt;
    dfp_addr = 32'h0000_4010; dfp_read = 1'b1; bmem_ready = 1'b0;
    tick;
    chk("t3_bread", bmem_read, 1'b1);
    tick;
    chk("t3_bread_hold", bmem_read, 1'b1);
    chk("t3_baddr", bmem_addr, 32'h0000_4000);
    bmem_ready = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_4000; bmem_rdata = bt3[k];
      tick;
      bmem_rvalid = 1'b0;
      if (k < 3) begin
        if (k == 1) begin
          bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_3000; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        tick;
        bmem_rvalid = 1'b0;
        chk("t3_gap_noresp", dfp_resp, 1'b0);
        tick;
      end
    end
    dfp_read = 1'b0;
    chk("t3_resp", dfp_resp, 1'b1);
    chk("t3_rdata", dfp_rdata, bt3);
    tick;
    chk("t3_one_resp", resp_cnt - base, 1);

    // 4: read and write both high -> write wins
    dfp_read = 1'b1;
    wr_line("t4", 32'h0000_5008, bt4);

    // 5: reset during beat 2 of a read, then a clean read
    base = resp_cnt;
    dfp_addr = 32'h0000_6000; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick; tick;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_6000; bmem_rdata = bt5[k];
      tick;
    end
    rst = 1'b1; bmem_rdata = bt5[2];
    tick;
    rst = 1'b0; dfp_read = 1'b0; bmem_rdata = bt5[3];
    chk("t5_rst_resp", dfp_resp, 1'b0);
    chk("t5_rst_rdata", dfp_rdata, '0);
    chk("t5_rst_bread", bmem_read, 1'b0);
    chk("t5_rst_baddr", bmem_addr, '0);
    tick;
    bmem_rvalid = 1'b0;
    tick; tick;
    chk("t5_late_beats_ignored", dfp_rdata, '0);
    chk("t5_no_resp", resp_cnt - base, 0);
    rd_line("t5_next", 32'h0000_7000, bt1);

    // 6: back-to-back I-read, D-write, D-read
    base = resp_cnt;
    rd_line("t6_iread", 32'h0000_8000, bt6);
    wr_line("t6_dwrite", 32'h0000_9004, bt2);
    rd_line("t6_dread", 32'h0000_A01F, bt3);
    chk("t6_resp_count", resp_cnt - base, 3);
    chk("rw_never_both", rw_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
